// File: rtl/dp_fifos_pkg.sv
// Shared types and default sizes for the FIFO write-side controller.
package dp_fifos_pkg;

   localparam int DefDataWidth     = 32;
   localparam int DefCountWidth    = 16;
   localparam int DefTimeoutCycles = 1023;

   // Controller states; encodings are fixed so they stay stable in debug dumps.
   localparam logic [2:0] StWaitRst  = 3'd0;
   localparam logic [2:0] StInRst    = 3'd1;
   localparam logic [2:0] StWaitDone = 3'd2;
   localparam logic [2:0] StRun      = 3'd3;
   localparam logic [2:0] StError    = 3'd4;

   typedef enum logic [2:0] {
      ST_WAIT_RST  = StWaitRst,
      ST_IN_RST    = StInRst,
      ST_WAIT_DONE = StWaitDone,
      ST_RUN       = StRun,
      ST_ERROR     = StError
   } state_e;

endpackage

// File: rtl/dp_fifos_skid_buf.sv
// Two-entry in-order buffer between the upstream stream and the FIFO write port.
// Push and pop may happen together; flush empties it and wins over both.
module dp_fifos_skid_buf
   import dp_fifos_pkg::*;
#(
   parameter int DataWidth = DefDataWidth
) (
   input  logic                 clk_i,
   input  logic                 arst_n_i,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 pop_i,
   input  logic                 flush_i,
   output logic [1:0]           entries_o,
   output logic [DataWidth-1:0] head_o
);

   logic [DataWidth-1:0] mem_q [2];
   logic [DataWidth-1:0] mem_d [2];
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic [1:0]           cnt_q, cnt_d;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   // Storage and pointer registers; storage resets to zero so the head reads 0.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign entries_o = cnt_q;
   assign head_o    = mem_q[rd_ptr_q];

endmodule

// File: rtl/dp_fifos_wr_ctrl.sv
// Write-side controller for the dual-port FIFO: gates the upstream stream into
// the FIFO only after a completed reset sequence, flushes on reset/SEE error,
// times out a missing reset-done, and counts written words.
module dp_fifos_wr_ctrl
   import dp_fifos_pkg::*;
#(
   parameter int DataWidth     = DefDataWidth,
   parameter int CountWidth    = DefCountWidth,
   parameter int TimeoutCycles = DefTimeoutCycles
) (
   input  logic                  clk_i,
   input  logic                  arst_n_i,
   input  logic                  fifo_rst_i,
   input  logic                  fifo_rst_done_i,
   input  logic                  seeerr_i,
   input  logic [DataWidth-1:0]  s_data_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   output logic [DataWidth-1:0]  fifo_din_o,
   output logic                  fifo_wr_en_o,
   input  logic                  fifo_full_i,
   output logic [CountWidth-1:0] wr_count_o,
   output logic                  flushed_o,
   output logic                  timeout_err_o,
   output logic                  run_o
);

   localparam int TimerWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
   localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

   state_e                state_q, state_d;
   logic [TimerWidth-1:0] timer_q, timer_d;
   logic [CountWidth-1:0] count_q, count_d;
   logic                  tmo_q, tmo_d;
   logic                  flushed_q, flushed_d;

   logic [1:0]            entries;
   logic                  push;
   logic                  leave_run;

   assign run_o        = (state_q == ST_RUN);
   assign s_ready_o    = run_o & (entries != 2'd2);
   assign fifo_wr_en_o = run_o & (entries != 2'd0) & ~fifo_full_i;
   assign push         = s_valid_i & s_ready_o;
   assign leave_run    = run_o & (state_d != ST_RUN);

   dp_fifos_skid_buf #(
      .DataWidth (DataWidth)
   ) u_skid (
      .clk_i     (clk_i),
      .arst_n_i  (arst_n_i),
      .push_i    (push),
      .data_i    (s_data_i),
      .pop_i     (fifo_wr_en_o),
      .flush_i   (leave_run),
      .entries_o (entries),
      .head_o    (fifo_din_o)
   );

   // State transitions, WAIT_DONE timer and sticky timeout flag.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      tmo_d   = tmo_q;
      if (seeerr_i) begin
         state_d = ST_ERROR;
      end else if (fifo_rst_i && (state_q != ST_ERROR)) begin
         state_d = ST_IN_RST;
      end else begin
         case (state_q)
            ST_WAIT_RST: begin
               if (fifo_rst_i) state_d = ST_IN_RST;
            end
            ST_IN_RST: begin
               if (!fifo_rst_i) begin
                  state_d = ST_WAIT_DONE;
                  timer_d = '0;
               end
            end
            ST_WAIT_DONE: begin
               if (fifo_rst_done_i) begin
                  state_d = ST_RUN;
               end else if (timer_q == TimerLast) begin
                  state_d = ST_ERROR;
                  tmo_d   = 1'b1;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            ST_ERROR: begin
               if (fifo_rst_i) state_d = ST_IN_RST;
            end
            default: begin
               state_d = ST_ERROR;
            end
         endcase
      end
      if (state_d == ST_IN_RST) begin
         tmo_d = 1'b0;
      end
   end

   // Written-word counter: cleared on entry to RUN, saturates at all-ones.
   always_comb begin
      count_d = count_q;
      if ((state_q == ST_WAIT_DONE) && (state_d == ST_RUN)) begin
         count_d = '0;
      end else if (fifo_wr_en_o && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Flag a discard only when words were actually sitting in the buffer.
   always_comb begin
      flushed_d = leave_run & (entries != 2'd0);
   end

   // Controller registers.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q   <= ST_WAIT_RST;
         timer_q   <= '0;
         count_q   <= '0;
         tmo_q     <= 1'b0;
         flushed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         count_q   <= count_d;
         tmo_q     <= tmo_d;
         flushed_q <= flushed_d;
      end
   end

   assign wr_count_o    = count_q;
   assign flushed_o     = flushed_q;
   assign timeout_err_o = tmo_q;

endmodule

// File: tb/tb_dp_fifos_wr_ctrl.sv
// Bench for dp_fifos_wr_ctrl: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_dp_fifos_wr_ctrl;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam int TC = 16;
   localparam int CNT_MAX = (1 << CW) - 1;

   localparam int M_WAIT_RST  = 0;
   localparam int M_IN_RST    = 1;
   localparam int M_WAIT_DONE = 2;
   localparam int M_RUN       = 3;
   localparam int M_ERROR     = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          frst = 1'b0;
   logic          done = 1'b0;
   logic          see = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          full = 1'b0;
   logic          s_ready;
   logic [DW-1:0] fifo_din;
   logic          fifo_wr_en;
   logic [CW-1:0] wr_count;
   logic          flushed;
   logic          timeout_err;
   logic          run;

   int errors = 0;
   int checks = 0;

   // model state
   int            m = M_WAIT_RST;
   logic [DW-1:0] q[$];
   int            waited = 0;
   int            cnt = 0;
   bit            tmo = 1'b0;
   bit            flx = 1'b0;
   bit            accepted = 1'b0;

   // observations and driver bookkeeping
   logic [DW-1:0] wlog[$];
   int            fcount = 0;
   int            seq = 1;
   bit            rand_mode = 1'b0;
   bit            verbose = 1'b1;

   always #5 clk = ~clk;

   dp_fifos_wr_ctrl #(
      .DataWidth     (DW),
      .CountWidth    (CW),
      .TimeoutCycles (TC)
   ) dut (
      .clk_i           (clk),
      .arst_n_i        (rst_n),
      .fifo_rst_i      (frst),
      .fifo_rst_done_i (done),
      .seeerr_i        (see),
      .s_data_i        (s_data),
      .s_valid_i       (s_valid),
      .s_ready_o       (s_ready),
      .fifo_din_o      (fifo_din),
      .fifo_wr_en_o    (fifo_wr_en),
      .fifo_full_i     (full),
      .wr_count_o      (wr_count),
      .flushed_o       (flushed),
      .timeout_err_o   (timeout_err),
      .run_o           (run)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what the block must do on each clock, from its rules.
   always @(posedge clk or negedge rst_n) begin : model
      int  nm;
      int  sz;
      bit  mrun, wr, acc;
      if (!rst_n) begin
         m = M_WAIT_RST;
         q.delete();
         waited = 0;
         cnt = 0;
         tmo = 1'b0;
         flx = 1'b0;
         accepted = 1'b0;
      end else begin
         sz   = q.size();
         mrun = (m == M_RUN);
         wr   = mrun && sz > 0 && !full;
         acc  = s_valid && mrun && sz < 2;
         accepted = acc;
         if (wr) begin
            void'(q.pop_front());
            if (cnt < CNT_MAX) cnt++;
         end
         if (acc) q.push_back(s_data);
         nm = m;
         if (see) nm = M_ERROR;
         else if (frst && m != M_ERROR) nm = M_IN_RST;
         else if (m == M_WAIT_RST && frst) nm = M_IN_RST;
         else if (m == M_IN_RST && !frst) begin
            nm = M_WAIT_DONE;
            waited = 0;
         end else if (m == M_WAIT_DONE) begin
            if (done) nm = M_RUN;
            else begin
               waited++;
               if (waited == TC) begin
                  nm = M_ERROR;
                  tmo = 1'b1;
               end
            end
         end else if (m == M_ERROR && frst) nm = M_IN_RST;
         if (nm == M_IN_RST) tmo = 1'b0;
         flx = (mrun && nm != M_RUN && sz > 0);
         if (mrun && nm != M_RUN) q.delete();
         if (m == M_WAIT_DONE && nm == M_RUN) cnt = 0;
         m = nm;
      end
   end

   // Compare DUT outputs to the model in the middle of every cycle.
   always @(negedge clk) begin : compare
      bit erun, erdy, ewr;
      erun = (m == M_RUN);
      erdy = erun && q.size() < 2;
      ewr  = erun && q.size() > 0 && !full;
      check("run_o", run, erun);
      check("s_ready_o", s_ready, erdy);
      check("fifo_wr_en_o", fifo_wr_en, ewr);
      if (ewr) check("fifo_din_o", fifo_din, q[0]);
      if (!rst_n) check("fifo_din_rst", fifo_din, 0);
      check("wr_count_o", wr_count, cnt);
      check("flushed_o", flushed, flx);
      check("timeout_err_o", timeout_err, tmo);
      if (fifo_wr_en) begin
         wlog.push_back(fifo_din);
         if (verbose) $display("write data=%0h count=%0d t=%0t", fifo_din, wr_count, $time);
      end
      if (flushed) fcount++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (accepted) begin
         seq++;
         s_data = rand_mode ? DW'($urandom) : DW'(seq);
      end
   endtask

   task automatic reset_seq();
      frst = 1'b1;
      repeat (3) tick();
      frst = 1'b0;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   initial begin
      int n;
      int first;
      int rst_left;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_run", run, 0);
      check("rst_ready", s_ready, 0);
      check("rst_wr_en", fifo_wr_en, 0);
      check("rst_count", wr_count, 0);
      check("rst_din", fifo_din, 0);
      check("rst_tmo", timeout_err, 0);
      rst_n = 1'b1;
      s_data = DW'(seq);

      // valid held while not yet running
      s_valid = 1'b1;
      repeat (3) begin
         tick();
         check("ready_wait_rst", s_ready, 0);
         check("wr_wait_rst", fifo_wr_en, 0);
      end
      frst = 1'b1;
      repeat (3) begin
         tick();
         check("ready_in_rst", s_ready, 0);
         check("wr_in_rst", fifo_wr_en, 0);
      end
      frst = 1'b0;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("run_after_done", run, 1);
      $display("phase: stream 8 words");
      n = 0;
      while (seq < 9 && n < 100) begin
         tick();
         n++;
      end
      s_valid = 1'b0;
      check("stream_bound", n < 100, 1);
      repeat (4) tick();
      check("count_8", wr_count, 8);
      check("wlog_size_8", wlog.size(), 8);
      for (int i = 0; i < wlog.size() && i < 8; i++) check("wlog_order", wlog[i], i + 1);
      check("no_flush", fcount, 0);

      // FIFO full back-pressure
      $display("phase: full back-pressure");
      first = seq;
      full = 1'b1;
      s_valid = 1'b1;
      repeat (5) tick();
      check("full_ready_low", s_ready, 0);
      check("full_no_wr", fifo_wr_en, 0);
      check("full_two_buffered", seq - first, 2);
      wlog.delete();
      full = 1'b0;
      n = 0;
      while (seq < first + 10 && n < 100) begin
         tick();
         n++;
      end
      s_valid = 1'b0;
      repeat (4) tick();
      check("resume_size", wlog.size(), 10);
      for (int i = 0; i < wlog.size() && i < 10; i++) check("resume_order", wlog[i], first + i);
      check("count_saturated", wr_count, CNT_MAX);

      // flush of buffered words on a new FIFO reset
      $display("phase: flush");
      full = 1'b1;
      s_valid = 1'b1;
      repeat (3) tick();
      s_valid = 1'b0;
      fcount = 0;
      frst = 1'b1;
      tick();
      check("flush_left_run", run, 0);
      repeat (2) tick();
      check("flush_once", fcount, 1);
      frst = 1'b0;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      full = 1'b0;
      check("flush_rerun", run, 1);
      check("flush_count_clr", wr_count, 0);

      // reset-done timeout
      $display("phase: timeout");
      frst = 1'b1;
      repeat (3) tick();
      frst = 1'b0;
      tick();
      for (int i = 0; i < TC - 1; i++) begin
         tick();
         check("tmo_early", timeout_err, 0);
      end
      tick();
      check("tmo_at_tc", timeout_err, 1);
      repeat (3) tick();
      check("tmo_sticky", timeout_err, 1);
      frst = 1'b1;
      tick();
      check("tmo_clear", timeout_err, 0);
      repeat (2) tick();
      frst = 1'b0;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("tmo_rerun", run, 1);

      // SEE error while streaming
      $display("phase: see error");
      s_valid = 1'b1;
      repeat (3) tick();
      see = 1'b1;
      tick();
      see = 1'b0;
      check("see_run_low", run, 0);
      check("see_no_wr", fifo_wr_en, 0);
      repeat (3) tick();
      check("see_stay_err", run, 0);
      reset_seq();
      check("see_rerun", run, 1);

      // random traffic
      $display("phase: random");
      verbose = 1'b0;
      rand_mode = 1'b1;
      rst_left = 0;
      for (int c = 0; c < 4000; c++) begin
         s_valid = ($urandom_range(0, 9) < 7);
         full    = ($urandom_range(0, 3) == 0);
         done    = ($urandom_range(0, 7) == 0);
         see     = ($urandom_range(0, 599) == 0);
         if (rst_left > 0) begin
            frst = 1'b1;
            rst_left--;
         end else begin
            frst = 1'b0;
            if ($urandom_range(0, 249) == 0) rst_left = $urandom_range(3, 5);
         end
         tick();
      end
      s_valid = 1'b0;
      frst = 1'b0;
      done = 1'b0;
      see = 1'b0;
      full = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
